// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Valid/ready handshake on both sides; the result is held until consumed.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic a0, b0, d, br_nx;

   always_comb begin
      a0    = a_sh_q[0];
      b0    = b_sh_q[0];
      d     = a0 ^ b0 ^ br_q;
      br_nx = (~a0 & b0) | (~(a0 ^ b0) & br_q);

      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // diff doubles as the result shift register; it is only
            // presented as valid once the last bit has landed.
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            diff_d = {d, diff_q[WIDTH-1:1]};
            br_d   = br_nx;
            if (cnt_q == CW'(WIDTH - 1)) begin
               borrow_d = br_nx;
               ovf_d    = (a_msb_q ^ b_msb_q) & (d ^ a_msb_q);
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results,
// a negedge monitor pops and compares on every consumed output.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .ovf       (ovf)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [W+1:0] exp_q[$];
   int           acc_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp = n_cmp + 1;
      if (act !== req) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      int ux, uy, sx, sy, r, dv;
      logic bw, ov;
      ux = int'(x);
      uy = int'(y);
      dv = (ux - uy + (1 << W)) % (1 << W);
      bw = (ux < uy);
      sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
      sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
      r  = sx - sy;
      ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      return {dv[W-1:0], bw, ov};
   endfunction

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("send_in_ready_timeout", 32'd0, 32'd1);
         return;
      end
      a        = x;
      b        = y;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_q.push_back(model(x, y));
      acc_q.push_back(cyc);
   endtask

   task automatic wait_valid();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("wait_out_valid_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: latency on rise, stability under backpressure, value on pop.
   logic         prev_ov   = 1'b0;
   logic         prev_hold = 1'b0;
   logic [W+1:0] prev_val  = '0;

   initial forever begin
      logic [W+1:0] e;
      int           t;
      @(negedge clk);
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (acc_q.size() > 0) begin
               t = acc_q.pop_front();
               chk("latency", cyc - t, W);
            end else begin
               chk("spurious_out_valid", 32'd1, 32'd0);
            end
         end
         if (prev_hold && out_valid)
            chk("hold_stable", {diff, borrow, ovf}, prev_val);
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("result", {diff, borrow, ovf}, e);
            end else begin
               chk("extra_result", 32'd1, 32'd0);
            end
            chk("in_ready_low_on_consume", in_ready, 1'b0);
         end
         prev_hold = out_valid && !out_ready;
         prev_val  = {diff, borrow, ovf};
      end
      prev_ov = out_valid;
   end

   initial begin
      logic [W+1:0] e;
      bit           done;
      int           seen;
      logic [W-1:0] ra, rb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      rst_n = 1'b1;

      out_ready = 1'b1;
      send(8'h05, 8'h03);
      send(8'h80, 8'h01);
      send(8'h00, 8'h00);
      wait_valid();
      @(negedge clk);

      // Backpressure hold
      out_ready = 1'b0;
      send(8'h03, 8'h05);
      e = model(8'h03, 8'h05);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1'b1);
         chk("bp_value", {diff, borrow, ovf}, e);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", out_valid, 1'b1);
      @(negedge clk);
      chk("bp_idle_in_ready", in_ready, 1'b1);
      chk("bp_idle_out_valid", out_valid, 1'b0);

      // in_valid toggling during RUN must be ignored
      out_ready = 1'b0;
      send(8'h05, 8'h03);
      a = 8'hFF;
      b = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid();
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (2 * W) @(negedge clk);
      chk("no_extra_accept", in_ready, 1'b1);

      // Reset in the middle of RUN
      send(8'h05, 8'h03);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      acc_q.delete();
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      chk("abort_outputs", {diff, borrow, ovf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_valid", seen, 0);
      send(8'h10, 8'h01);
      wait_valid();
      @(negedge clk);

      // Random back-to-back with random backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               case ($urandom_range(0, 5))
                  0: ra = 8'h00;
                  1: ra = 8'h80;
                  2: ra = 8'h7F;
                  3: ra = 8'hFF;
                  default: ra = W'($urandom);
               endcase
               rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
               if ($urandom_range(0, 5) == 0) rb = 8'h80;
               send(ra, rb);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      repeat (4) @(negedge clk);
      chk("drain_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
